// File: rtl/regfile_mp_sb.sv
// Multi-port register file with write-first bypass and per-register pending-write scoreboard.
// Optional even-parity storage and error injection enabled by defining REGFILE_PARITY_EN.
module regfile_mp_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS),
  parameter int NRD   = 2,
  parameter int NWR   = 2,
  parameter int CW    = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NWR-1:0]       wr_en_i,
  input  logic [NWR*AW-1:0]    wr_addr_i,
  input  logic [NWR*XLEN-1:0]  wr_data_i,
  input  logic [NWR-1:0]       wr_retire_i,
  input  logic [NRD*AW-1:0]    rd_addr_i,
  output logic [NRD*XLEN-1:0]  rd_data_o,
  output logic [NRD-1:0]       rd_ready_o,
  input  logic                 iss_valid_i,
  input  logic [AW-1:0]        iss_addr_i,
  output logic                 iss_ready_o,
  output logic                 sb_err_o,
  input  logic [AW-1:0]        dbg_addr_i,
  output logic [XLEN-1:0]      dbg_data_o
`ifdef REGFILE_PARITY_EN
  ,
  output logic [NRD-1:0]       rd_perr_o,
  input  logic                 dbg_flip_en_i
`endif
);

  localparam int DW = $clog2(NWR + 1);

  logic [XLEN-1:0] mem_q [NREGS];
  logic [XLEN-1:0] mem_d [NREGS];
  logic [CW-1:0]   cnt_q [NREGS];
  logic [CW-1:0]   cnt_d [NREGS];
  logic [DW-1:0]   dec_r [NREGS];
  logic            sb_err_q, sb_err_d;
`ifdef REGFILE_PARITY_EN
  logic            par_q [NREGS];
  logic            par_d [NREGS];
`endif

  // Array update: ports applied in ascending order so the highest index wins.
  always_comb begin : wr_path
    logic [AW-1:0] wa;
    wa = '0;
    mem_d = mem_q;
`ifdef REGFILE_PARITY_EN
    par_d = par_q;
`endif
    for (int k = 0; k < NWR; k++) begin
      wa = wr_addr_i[k*AW +: AW];
      if (wr_en_i[k] && (wa != '0)) begin
        mem_d[wa] = wr_data_i[k*XLEN +: XLEN];
`ifdef REGFILE_PARITY_EN
        par_d[wa] = ^wr_data_i[k*XLEN +: XLEN];
`endif
      end
    end
`ifdef REGFILE_PARITY_EN
    // Injection corrupts data only; parity keeps the value computed at write time.
    if (dbg_flip_en_i && (dbg_addr_i != '0)) begin
      mem_d[dbg_addr_i][0] = ~mem_d[dbg_addr_i][0];
    end
`endif
  end

  // Retires per register this cycle; address 0 retires are never counted.
  always_comb begin : dec_path
    for (int r = 0; r < NREGS; r++) begin
      dec_r[r] = '0;
      if (r != 0) begin
        for (int k = 0; k < NWR; k++) begin
          if (wr_en_i[k] && wr_retire_i[k] && (wr_addr_i[k*AW +: AW] == AW'(r))) begin
            dec_r[r] = dec_r[r] + DW'(1);
          end
        end
      end
    end
  end

  assign iss_ready_o = (iss_addr_i == '0) || (cnt_q[iss_addr_i] != {CW{1'b1}});

  always_comb begin : sb_path
    logic        inc;
    logic [31:0] tot;
    inc      = 1'b0;
    tot      = '0;
    sb_err_d = sb_err_q;
    for (int r = 0; r < NREGS; r++) begin
      cnt_d[r] = cnt_q[r];
    end
    for (int r = 1; r < NREGS; r++) begin
      inc = iss_valid_i && iss_ready_o && (iss_addr_i == AW'(r));
      tot = 32'(cnt_q[r]) + 32'(inc);
      if (32'(dec_r[r]) > tot) begin
        cnt_d[r] = '0;
        sb_err_d = 1'b1;
      end else begin
        cnt_d[r] = CW'(tot - 32'(dec_r[r]));
      end
    end
  end

  always_comb begin : rd_path
    logic [AW-1:0] ra;
    logic          byp;
    ra         = '0;
    byp        = 1'b0;
    rd_data_o  = '0;
    rd_ready_o = '0;
`ifdef REGFILE_PARITY_EN
    rd_perr_o  = '0;
`endif
    for (int j = 0; j < NRD; j++) begin
      ra  = rd_addr_i[j*AW +: AW];
      byp = 1'b0;
      rd_data_o[j*XLEN +: XLEN] = mem_q[ra];
      for (int k = 0; k < NWR; k++) begin
        if (wr_en_i[k] && (wr_addr_i[k*AW +: AW] == ra)) begin
          byp = 1'b1;
          rd_data_o[j*XLEN +: XLEN] = wr_data_i[k*XLEN +: XLEN];
        end
      end
      if (ra == '0) begin
        rd_data_o[j*XLEN +: XLEN] = '0;
      end
      // The last producer retiring now makes the operand usable through the bypass.
      rd_ready_o[j] = (ra == '0) || (32'(cnt_q[ra]) <= 32'(dec_r[ra]));
`ifdef REGFILE_PARITY_EN
      rd_perr_o[j] = !byp && (ra != '0) && ((^mem_q[ra]) != par_q[ra]);
`endif
    end
  end

  assign dbg_data_o = (dbg_addr_i == '0) ? '0 : mem_q[dbg_addr_i];
  assign sb_err_o   = sb_err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < NREGS; r++) begin
        mem_q[r] <= '0;
        cnt_q[r] <= '0;
`ifdef REGFILE_PARITY_EN
        par_q[r] <= 1'b0;
`endif
      end
      sb_err_q <= 1'b0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        mem_q[r] <= mem_d[r];
        cnt_q[r] <= cnt_d[r];
`ifdef REGFILE_PARITY_EN
        par_q[r] <= par_d[r];
`endif
      end
      sb_err_q <= sb_err_d;
    end
  end

endmodule
